imem_loader: RTL and testbench
==============================

# imem_loader

Sequential writer for the byte-wide instruction memory. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes each word as four consecutive byte writes. Byte order is big-endian: the most significant byte goes to the lowest address, which matches the read path `rd = {mem[a], mem[a+1], mem[a+2], mem[a+3]}`. It sits between a program source (test bench, boot ROM or debug port) and the write port of the instruction memory, and pre-loads the program before the core leaves reset.

## Interface
Parameters:
- ADDR_BUS_WIDTH, 5, byte-address width; memory depth is 2**ADDR_BUS_WIDTH bytes
- DATA_BUS_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word)
- BASE_ADDR, 0, byte address of the first written byte; must be a multiple of 4

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a load; sampled only in IDLE
- word_count  input  ADDR_BUS_WIDTH  number of words to load; sampled with start
- s_valid  input  1  source word valid
- s_ready  output  1  loader can accept a word
- s_data  input  DATA_BUS_WIDTH  source instruction word
- we  output  1  byte write enable to the instruction memory
- wa  output  ADDR_BUS_WIDTH  byte write address
- wd  output  8  byte write data
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when a load ends, whether it completes or is rejected
- err  output  1  sticky range error; cleared by the next accepted start or by rst
- checksum  output  DATA_BUS_WIDTH  present only when IMEM_LOADER_CHECKSUM_EN is defined

## Operation
- FSM states: IDLE, ACCEPT, WRITE, DONE. All outputs are Moore outputs decoded from registers.
- IDLE:
  - start=1 latches word_count into words_left, sets addr=BASE_ADDR, and clears err.
  - Range check: if BASE_ADDR + 4*word_count > 2**ADDR_BUS_WIDTH, set err=1 and go to DONE with no writes.
  - Otherwise, word_count=0 goes to DONE with no writes, and word_count>0 goes to ACCEPT.
- ACCEPT: s_ready=1. When s_valid&s_ready, capture s_data into word_q, set byte_idx=0 and go to WRITE. While s_valid=0, stay in ACCEPT indefinitely.
- WRITE: we=1, wa=addr, wd=word_q byte selected by byte_idx:
  - byte_idx 0 → word_q[31:24]
  - byte_idx 1 → word_q[23:16]
  - byte_idx 2 → word_q[15:8]
  - byte_idx 3 → word_q[7:0]
  - Each cycle: addr+1 and byte_idx+1. On byte_idx=3, decrement words_left; if the result is 0 go to DONE, else go to ACCEPT.
- DONE: done=1 for one cycle, then go to IDLE.
- addr arithmetic is modulo 2**ADDR_BUS_WIDTH. The range check guarantees no wrap during a legal load. A load ending exactly at the top byte is legal.
- start outside IDLE is ignored. s_data is ignored outside the ACCEPT handshake.
- s_ready is 0 in every state other than ACCEPT.

## Timing
- Reset values: state=IDLE, s_ready=0, we=0, wa=0, wd=0, busy=0, done=0, err=0, checksum=0.
- start sampled at edge 0 → ACCEPT (busy=1, s_ready=1) in cycle 1.
- Handshake in cycle k → byte writes in cycles k+1..k+4. The memory captures each byte on the closing edge of its cycle.
- Next ACCEPT (or DONE) in cycle k+5. Peak throughput is 1 word per 5 cycles.
- Rejected or zero-length load: DONE in cycle 1, IDLE in cycle 2.
- rst asserted mid-load: the next edge forces IDLE with we=0. Bytes already written stay in memory; no partial word is completed.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - checksum accumulates the 32-bit wrapping sum of every accepted s_data.
  - It is cleared on an accepted start, updated on the handshake edge, and stable from the done pulse until the next start.
- Not defined: no checksum port and no accumulator logic.

## Structure
- Shared package imem_pkg holds:
  - the state enum loader_state_t (IDLE, ACCEPT, WRITE, DONE)
  - BYTES_PER_WORD=4
  - the byte-lane select function (big-endian)
- No sub-module is required. The byte serializer (word_q + byte_idx) may be split out as imem_byte_serializer if the same logic is reused by a data-memory loader.

## Test plan
- Load 2 words at BASE_ADDR=4: 0xFFC4A303, 0x00030000 → writes at addr 4..11 are FF,C4,A3,03,00,03,00,00. Memory read at a=4 returns 0xFFC4A303; done pulses once; err=0.
- Hold s_valid=0 for 7 cycles in ACCEPT → we stays 0 and state stays ACCEPT. The word arriving afterwards is written correctly.
- word_count=9 with BASE_ADDR=0 and depth 32 → err=1, done in cycle 1, zero writes. A following legal start clears err.
- word_count=8 with BASE_ADDR=0 → last write at wa=31, no err. word_count=0 → done in cycle 1, no writes.
- Assert rst during the 2nd byte of a word → next cycle state=IDLE, we=0, busy=0. Only the first byte was written.
- With IMEM_LOADER_CHECKSUM_EN: words 0xFFFFFFFF and 0x00000002 → checksum=0x00000001 at the done pulse.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, word geometry
// and the big-endian byte-lane select.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WRITE,
    DONE
  } loader_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;

  // Lane 0 is the most significant byte so the word reads back as
  // {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Source handshake plus byte write port of the instruction-memory loader.
// slave = loader side, master = source / memory side.
interface imem_loader_if #(
  parameter int ADDR_BUS_WIDTH = 5,
  parameter int DATA_BUS_WIDTH = 32
);
  logic                      s_valid;
  logic                      s_ready;
  logic [DATA_BUS_WIDTH-1:0] s_data;
  logic                      we;
  logic [ADDR_BUS_WIDTH-1:0] wa;
  logic [7:0]                wd;

  modport slave (
    input  s_valid, s_data,
    output s_ready, we, wa, wd
  );

  modport master (
    output s_valid, s_data,
    input  s_ready, we, wa, wd
  );
endinterface

// File: rtl/imem_loader.sv
// Sequential word-to-byte writer for the instruction memory (big-endian).
// Optional feature: IMEM_LOADER_CHECKSUM_EN adds a wrapping sum of accepted words.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_BUS_WIDTH = 5,
  parameter int DATA_BUS_WIDTH = 32,
  parameter int BASE_ADDR      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_BUS_WIDTH-1:0] word_count,
  imem_loader_if.slave              bus,
  output logic                      busy,
  output logic                      done,
  output logic                      err
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_BUS_WIDTH-1:0] checksum
`endif
);

  localparam int EW = ADDR_BUS_WIDTH + 3;

  loader_state_t             state;
  logic [ADDR_BUS_WIDTH-1:0] words_left;
  logic [ADDR_BUS_WIDTH-1:0] addr;
  logic [1:0]                byte_idx;
  logic [DATA_BUS_WIDTH-1:0] word_q;
  logic [EW-1:0]             load_end;
  logic                      range_bad;

  // Evaluated with three extra bits so a load ending exactly at the top is legal.
  assign load_end  = EW'(BASE_ADDR) + {1'b0, word_count, 2'b00};
  assign range_bad = load_end > (EW'(1) << ADDR_BUS_WIDTH);

  assign bus.wa = addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      words_left  <= '0;
      addr        <= '0;
      byte_idx    <= '0;
      word_q      <= '0;
      bus.s_ready <= 1'b0;
      bus.we      <= 1'b0;
      bus.wd      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            words_left <= word_count;
            addr       <= ADDR_BUS_WIDTH'(BASE_ADDR);
            busy       <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum   <= '0;
`endif
            if (range_bad || word_count == '0) begin
              err   <= range_bad;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              err         <= 1'b0;
              bus.s_ready <= 1'b1;
              state       <= ACCEPT;
            end
          end
        end

        ACCEPT: begin
          if (bus.s_valid) begin
            word_q      <= bus.s_data;
            byte_idx    <= '0;
            bus.s_ready <= 1'b0;
            bus.we      <= 1'b1;
            bus.wd      <= byte_lane(bus.s_data, 2'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum    <= checksum + bus.s_data;
`endif
            state       <= WRITE;
          end
        end

        WRITE: begin
          addr     <= addr + ADDR_BUS_WIDTH'(1);
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'(BYTES_PER_WORD - 1)) begin
            words_left <= words_left - ADDR_BUS_WIDTH'(1);
            bus.we     <= 1'b0;
            if (words_left == ADDR_BUS_WIDTH'(1)) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              bus.s_ready <= 1'b1;
              state       <= ACCEPT;
            end
          end else begin
            bus.wd <= byte_lane(word_q, byte_idx + 2'd1);
          end
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader (BASE_ADDR=4, 32-byte memory).
// Define IMEM_LOADER_CHECKSUM_EN to also check the checksum port.
module tb_imem_loader;
  import imem_pkg::*;

  localparam int AW    = 5;
  localparam int BASE  = 4;
  localparam int DEPTH = 32;

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] word_count = '0;
  logic          busy, done, err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  imem_loader_if #(.ADDR_BUS_WIDTH(AW), .DATA_BUS_WIDTH(32)) bus ();

  imem_loader #(.ADDR_BUS_WIDTH(AW), .DATA_BUS_WIDTH(32), .BASE_ADDR(BASE)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .bus        (bus.slave),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  int          last_wa = -1;
  wr_t         exp_q[$];
  logic [31:0] words[$];
  logic [7:0]  tb_mem [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every byte the DUT writes must be the next one the model predicted.
  always @(negedge clk) begin
    if (!rst && bus.we) begin
      tb_mem[bus.wa] = bus.wd;
      last_wa = int'(bus.wa);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: wa=%0d wd=%h, expected no write", bus.wa, bus.wd);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(bus.wa), 32'(e.a));
        chk("write_data", 32'(bus.wd), 32'(e.d));
      end
    end
    if (!rst && done) done_cnt++;
  end

  // Drives one load of n words taken from `words`; expectations come from the
  // byte-address rule: word i byte j lands at BASE+4i+j, MSB first.
  task automatic do_load(input int unsigned n, input int unsigned max_gap);
    logic        bad;
    int          d0;
    logic [31:0] sum;
    bad = (BASE + 4 * n) > DEPTH;
    d0  = done_cnt;
    sum = '0;
    @(posedge clk); #1;
    start = 1'b1;
    word_count = AW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    word_count = AW'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
    if (bad || n == 0) begin
      chk("early_done", 32'(done), 32'd1);
      chk("err_early", 32'(err), 32'(bad));
      chk("ready_no_load", 32'(bus.s_ready), 32'd0);
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        logic [31:0] w;
        int unsigned g;
        w = words[i];
        sum += w;
        chk("ready_accept", 32'(bus.s_ready), 32'd1);
        g = $urandom_range(max_gap, 0);
        repeat (g) begin
          bus.s_valid = 1'b0;
          bus.s_data  = $urandom;
          @(posedge clk); #1;
          chk("we_while_waiting", 32'(bus.we), 32'd0);
        end
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        for (int j = 0; j < 4; j++)
          exp_q.push_back('{a: AW'(BASE + 4 * i + j), d: 8'(w >> (24 - 8 * j))});
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        bus.s_data  = $urandom;
        chk("ready_in_write", 32'(bus.s_ready), 32'd0);
        chk("we_in_write", 32'(bus.we), 32'd1);
        repeat (4) @(posedge clk);
        #1;
      end
      chk("final_done", 32'(done), 32'd1);
      chk("err_legal", 32'(err), 32'd0);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("checksum", checksum, sum);
`endif
    @(posedge clk); #1;
    chk("busy_end", 32'(busy), 32'd0);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] saved;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    for (int i = 0; i < DEPTH; i++) tb_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_wa", 32'(bus.wa), 32'd0);
    chk("rst_wd", 32'(bus.wd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("rst_checksum", checksum, 32'd0);
`endif
    rst = 1'b0;

    words = '{32'hFFC4A303, 32'h00030000};
    do_load(2, 0);
    chk("readback_4", {tb_mem[4], tb_mem[5], tb_mem[6], tb_mem[7]}, 32'hFFC4A303);
    chk("readback_8", {tb_mem[8], tb_mem[9], tb_mem[10], tb_mem[11]}, 32'h00030000);

    words = '{32'h12345678};
    do_load(1, 7);

    do_load(8, 0);
    chk("err_sticky", 32'(err), 32'd1);
    words = '{32'hCAFEF00D};
    do_load(1, 0);
    chk("err_cleared", 32'(err), 32'd0);

    words.delete();
    for (int i = 0; i < 7; i++) words.push_back($urandom);
    do_load(7, 1);
    chk("top_byte_written", 32'(last_wa), 32'd31);

    do_load(0, 0);

    words = '{32'hFFFFFFFF, 32'h00000002};
    do_load(2, 0);

    for (int t = 0; t < 8; t++) begin
      int unsigned n;
      n = $urandom_range(9, 0);
      words.delete();
      for (int i = 0; i < int'(n); i++) words.push_back($urandom);
      do_load(n, 2);
    end

    // Reset during the second byte: only the first byte may land.
    saved = tb_mem[BASE + 1];
    @(posedge clk); #1;
    start = 1'b1;
    word_count = AW'(2);
    @(posedge clk); #1;
    start = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hA1B2C3D4;
    exp_q.push_back('{a: AW'(BASE), d: 8'hA1});
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_state", 32'(u_dut.state), 32'(IDLE));
    chk("rst_mid_we", 32'(bus.we), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ready", 32'(bus.s_ready), 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_first_byte", 32'(tb_mem[BASE]), 32'hA1);
    chk("rst_mid_second_untouched", 32'(tb_mem[BASE + 1]), 32'(saved));
    chk("rst_mid_queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
